// File: rtl/core_pkg.sv
// Shared trap-sequencing types, mstatus field positions and the mstatus
// rewrite helpers used on trap entry and MRET.
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_SAVE     = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_IRQ  = 2'd1,
    KIND_MRET = 2'd2
  } trap_kind_e;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LSB  = 11;
  localparam logic [1:0]  PRIV_M           = 2'b11;

  // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as prior.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MPIE_BIT] = m[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT]  = 1'b0;
    r[MSTATUS_MPP_LSB +: 2] = PRIV_M;
    return r;
  endfunction

  // MRET: restore MIE from MPIE and re-arm MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE_BIT]  = m[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT] = 1'b1;
    r[MSTATUS_MPP_LSB +: 2] = PRIV_M;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: accepts exception/MRET/interrupt, drains the
// pipe, writes mepc/mcause/mstatus, then issues one redirect with flush.
module trap_sequencer
  import core_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_valid_i,
  input  logic [31:0] irq_handler_i,
  input  logic [31:0] irq_cause_i,
  input  logic [31:0] irq_epc_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic        pipe_idle_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        mepc_we_o,
  output logic [31:0] mepc_o,
  output logic        mcause_we_o,
  output logic [31:0] mcause_o,
  output logic        mstatus_we_o,
  output logic [31:0] mstatus_o,
  output logic        trap_active_o
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  trap_state_e state_q, state_d;
  trap_kind_e  kind_q, kind_d;
  logic [31:0] cause_q, cause_d, epc_q, epc_d, target_q, target_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        stall_d, flush_d, redir_d, mepc_we_d, mcause_we_d, mstatus_we_d;
  logic [31:0] pc_d, mepc_d, mcause_d, mstatus_d;

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    stall_d      = 1'b0;
    flush_d      = 1'b0;
    redir_d      = 1'b0;
    pc_d         = '0;
    mepc_we_d    = 1'b0;
    mepc_d       = '0;
    mcause_we_d  = 1'b0;
    mcause_d     = '0;
    mstatus_we_d = 1'b0;
    mstatus_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid_i) begin
          kind_d   = KIND_EXC;
          target_d = {mtvec_i[31:2], 2'b00};
          epc_d    = exc_pc_i;
          cause_d  = exc_cause_i;
          cnt_d    = DRAIN_LOAD;
          state_d  = ST_DRAIN;
        end else if (mret_i) begin
          kind_d   = KIND_MRET;
          target_d = mepc_i;
          state_d  = ST_REDIRECT;
        end else if (irq_valid_i) begin
          kind_d   = KIND_IRQ;
          target_d = irq_handler_i;
          epc_d    = irq_epc_i;
          cause_d  = irq_cause_i;
          cnt_d    = DRAIN_LOAD;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Minimum dwell is enforced by the counter; the idle wait has no timeout.
        if (cnt_q == 4'd0) begin
          if (pipe_idle_i) state_d = ST_SAVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAVE:     state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    stall_d = (state_d != ST_IDLE);
    if (state_d == ST_SAVE) begin
      mepc_we_d    = 1'b1;
      mepc_d       = {epc_d[31:2], 2'b00};
      mcause_we_d  = 1'b1;
      mcause_d     = cause_d;
      mstatus_we_d = 1'b1;
      mstatus_d    = trap_mstatus(mstatus_i);
    end
    if (state_d == ST_REDIRECT) begin
      redir_d = 1'b1;
      flush_d = 1'b1;
      pc_d    = target_d;
      if (kind_d == KIND_MRET) begin
        mstatus_we_d = 1'b1;
        mstatus_d    = mret_mstatus(mstatus_i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      kind_q           <= KIND_EXC;
      cause_q          <= '0;
      epc_q            <= '0;
      target_q         <= '0;
      cnt_q            <= '0;
      stall_o          <= 1'b0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      mepc_we_o        <= 1'b0;
      mepc_o           <= '0;
      mcause_we_o      <= 1'b0;
      mcause_o         <= '0;
      mstatus_we_o     <= 1'b0;
      mstatus_o        <= '0;
      trap_active_o    <= 1'b0;
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      cause_q          <= cause_d;
      epc_q            <= epc_d;
      target_q         <= target_d;
      cnt_q            <= cnt_d;
      stall_o          <= stall_d;
      flush_o          <= flush_d;
      redirect_valid_o <= redir_d;
      redirect_pc_o    <= pc_d;
      mepc_we_o        <= mepc_we_d;
      mepc_o           <= mepc_d;
      mcause_we_o      <= mcause_we_d;
      mcause_o         <= mcause_d;
      mstatus_we_o     <= mstatus_we_d;
      mstatus_o        <= mstatus_d;
      trap_active_o    <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboarded bench for trap_sequencer: scenario tasks push the CSR writes
// and redirects they expect; a negedge monitor pops and checks them.
module tb_trap_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        irq_valid_i;
  logic [31:0] irq_handler_i, irq_cause_i, irq_epc_i;
  logic        exc_valid_i;
  logic [31:0] exc_cause_i, exc_pc_i;
  logic        mret_i;
  logic [31:0] mtvec_i, mepc_i, mstatus_i;
  logic        pipe_idle_i;
  logic        stall_o, flush_o, redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        mepc_we_o, mcause_we_o, mstatus_we_o;
  logic [31:0] mepc_o, mcause_o, mstatus_o;
  logic        trap_active_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        redir;
    logic [31:0] pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        mst_we;
    logic [31:0] mstatus;
  } exp_t;
  exp_t sb[$];

  trap_sequencer #(.DRAIN_CYCLES(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .irq_valid_i(irq_valid_i), .irq_handler_i(irq_handler_i),
    .irq_cause_i(irq_cause_i), .irq_epc_i(irq_epc_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
    .mret_i(mret_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
    .pipe_idle_i(pipe_idle_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o),
    .mepc_we_o(mepc_we_o), .mepc_o(mepc_o),
    .mcause_we_o(mcause_we_o), .mcause_o(mcause_o),
    .mstatus_we_o(mstatus_we_o), .mstatus_o(mstatus_o),
    .trap_active_o(trap_active_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every CSR save and every redirect must match the next scoreboard entry.
  always @(negedge clk_i) begin
    if (!rst_i && (mepc_we_o || mcause_we_o || redirect_valid_o ||
                   (mstatus_we_o && !redirect_valid_o))) begin
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: redirect=%0b mepc_we=%0b pc=%h, expected no event",
                 redirect_valid_o, mepc_we_o, redirect_pc_o);
      end else begin
        e = sb.pop_front();
        if (!e.redir) begin
          if ({redirect_valid_o, flush_o, mepc_we_o, mcause_we_o, mstatus_we_o, stall_o} !== 6'b001111 ||
              mepc_o !== e.mepc || mcause_o !== e.mcause || mstatus_o !== e.mstatus) begin
            miscompares++;
            $display("FAIL save: got mepc=%h mcause=%h mstatus=%h strobes=%b, expected mepc=%h mcause=%h mstatus=%h strobes=001111",
                     mepc_o, mcause_o, mstatus_o,
                     {redirect_valid_o, flush_o, mepc_we_o, mcause_we_o, mstatus_we_o, stall_o},
                     e.mepc, e.mcause, e.mstatus);
          end
        end else begin
          if ({redirect_valid_o, flush_o, mepc_we_o, mcause_we_o, stall_o} !== 5'b11001 ||
              redirect_pc_o !== e.pc || mstatus_we_o !== e.mst_we ||
              (e.mst_we && mstatus_o !== e.mstatus)) begin
            miscompares++;
            $display("FAIL redirect: got pc=%h mstatus_we=%0b mstatus=%h flags=%b, expected pc=%h mstatus_we=%0b mstatus=%h flags=11001",
                     redirect_pc_o, mstatus_we_o, mstatus_o,
                     {redirect_valid_o, flush_o, mepc_we_o, mcause_we_o, stall_o},
                     e.pc, e.mst_we, e.mstatus);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet_inputs();
    irq_valid_i = 0; irq_handler_i = 0; irq_cause_i = 0; irq_epc_i = 0;
    exc_valid_i = 0; exc_cause_i = 0; exc_pc_i = 0;
    mret_i = 0; mtvec_i = 0; mepc_i = 0; mstatus_i = 0; pipe_idle_i = 1;
  endtask

  task automatic push_trap(input logic [31:0] mepc, input logic [31:0] mcause,
                           input logic [31:0] mstatus, input logic [31:0] pc);
    sb.push_back('{redir: 1'b0, pc: 32'h0, mepc: mepc, mcause: mcause, mst_we: 1'b1, mstatus: mstatus});
    sb.push_back('{redir: 1'b1, pc: pc, mepc: 32'h0, mcause: 32'h0, mst_we: 1'b0, mstatus: 32'h0});
  endtask

  // Ticks until redirect_valid_o is visible; n = extra ticks taken, -1 on timeout.
  task automatic wait_redirect(output int n);
    n = 0;
    while (!redirect_valid_o && n < 64) begin
      tick();
      n++;
    end
    if (!redirect_valid_o) n = -1;
  endtask

  task automatic check_drained(input string name);
    tick();
    vectors++;
    if (trap_active_o !== 1'b0 || stall_o !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_return_idle: active=%0b stall=%0b pending=%0d, expected 0 0 0",
               name, trap_active_o, stall_o, sb.size());
    end
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst_i = 1;
    tick();
    tick();
    vectors++;
    if ({stall_o, flush_o, redirect_valid_o, redirect_pc_o, mepc_we_o, mepc_o, mcause_we_o,
         mcause_o, mstatus_we_o, mstatus_o, trap_active_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: stall=%0b active=%0b pc=%h mepc=%h, expected all 0",
               stall_o, trap_active_o, redirect_pc_o, mepc_o);
    end
    rst_i = 0;
    tick();
  endtask

  task automatic test_irq();
    int n;
    irq_valid_i = 1; irq_handler_i = 32'h0000_012C; irq_cause_i = 32'h8000_0007;
    irq_epc_i = 32'h0000_0400; mstatus_i = 32'h0000_0008; pipe_idle_i = 1;
    push_trap(32'h0000_0400, 32'h8000_0007, 32'h0000_1880, 32'h0000_012C);
    tick();
    vectors++;
    if (stall_o !== 1'b1 || trap_active_o !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_stall_start: stall=%0b active=%0b, expected 1 1", stall_o, trap_active_o);
    end
    wait_redirect(n);
    irq_valid_i = 0;
    vectors++;
    if (n + 1 != 5) begin
      miscompares++;
      $display("FAIL irq_latency: got %0d cycles, expected 5", n + 1);
    end
    check_drained("irq");
  endtask

  task automatic test_exc_over_irq();
    int n;
    exc_valid_i = 1; exc_cause_i = 32'd2; exc_pc_i = 32'h0000_0200; mtvec_i = 32'h0000_0101;
    irq_valid_i = 1; irq_handler_i = 32'h0000_0999; irq_cause_i = 32'h8000_0003;
    irq_epc_i = 32'h0000_0777; mstatus_i = 32'h0000_0008;
    push_trap(32'h0000_0200, 32'd2, 32'h0000_1880, 32'h0000_0100);
    tick();
    exc_valid_i = 0;
    wait_redirect(n);
    irq_valid_i = 0;
    vectors++;
    if (n + 1 != 5) begin
      miscompares++;
      $display("FAIL exc_latency: got %0d cycles, expected 5", n + 1);
    end
    check_drained("exc");
  endtask

  task automatic test_pipe_busy();
    int n;
    irq_valid_i = 1; irq_handler_i = 32'h0000_0500; irq_cause_i = 32'h8000_000B;
    irq_epc_i = 32'h0000_0C00; mstatus_i = 32'h0000_0008; pipe_idle_i = 0;
    push_trap(32'h0000_0C00, 32'h8000_000B, 32'h0000_1880, 32'h0000_0500);
    tick();
    irq_valid_i = 0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (stall_o !== 1'b1 || mepc_we_o !== 1'b0 || mcause_we_o !== 1'b0 || mstatus_we_o !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_hold_%0d: stall=%0b strobes=%b, expected stall=1 strobes=000",
                 i, stall_o, {mepc_we_o, mcause_we_o, mstatus_we_o});
      end
      if (i < 9) tick();
    end
    pipe_idle_i = 1;
    tick();
    vectors++;
    if (mepc_we_o !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_release: mepc_we=%0b one cycle after idle, expected 1", mepc_we_o);
    end
    wait_redirect(n);
    vectors++;
    if (n != 1) begin
      miscompares++;
      $display("FAIL busy_redirect: got %0d cycles after save, expected 1", n);
    end
    check_drained("busy");
  endtask

  task automatic test_mret();
    int n;
    mret_i = 1; mepc_i = 32'h0000_0400; mstatus_i = 32'h0000_1880;
    sb.push_back('{redir: 1'b1, pc: 32'h0000_0400, mepc: 32'h0, mcause: 32'h0, mst_we: 1'b1, mstatus: 32'h0000_1888});
    tick();
    mret_i = 0;
    wait_redirect(n);
    vectors++;
    if (n != 0) begin
      miscompares++;
      $display("FAIL mret_latency: got %0d cycles, expected 1", n + 1);
    end
    check_drained("mret");
  endtask

  task automatic test_irq_pulse();
    int n;
    irq_valid_i = 1; irq_handler_i = 32'h0000_0300; irq_cause_i = 32'h8000_000B;
    irq_epc_i = 32'h0000_0402; mstatus_i = 32'h0000_0008;
    push_trap(32'h0000_0400, 32'h8000_000B, 32'h0000_1880, 32'h0000_0300);
    tick();
    irq_valid_i = 0; irq_cause_i = 32'hDEAD_BEEF; irq_handler_i = 32'h0BAD_0000; irq_epc_i = 32'h1234_5678;
    wait_redirect(n);
    vectors++;
    if (n + 1 != 5) begin
      miscompares++;
      $display("FAIL pulse_latency: got %0d cycles, expected 5", n + 1);
    end
    check_drained("pulse");
  endtask

  task automatic test_back_to_back();
    int n;
    exc_valid_i = 1; exc_cause_i = 32'd5; exc_pc_i = 32'h0000_1003;
    mtvec_i = 32'h8000_0003; mstatus_i = 32'h0000_1800;
    push_trap(32'h0000_1000, 32'd5, 32'h0000_1800, 32'h8000_0000);
    tick();
    exc_valid_i = 0;
    mret_i = 1; mepc_i = 32'h0000_4444;
    tick();
    mret_i = 0;
    wait_redirect(n);
    exc_valid_i = 1; exc_cause_i = 32'h0000_000B; exc_pc_i = 32'h0000_2000; mstatus_i = 32'h0000_0080;
    push_trap(32'h0000_2000, 32'h0000_000B, 32'h0000_1800, 32'h8000_0000);
    tick();
    tick();
    exc_valid_i = 0;
    wait_redirect(n);
    vectors++;
    if (n < 0) begin
      miscompares++;
      $display("FAIL b2b_second: no redirect within bound, expected one");
    end
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_save();
    int n;
    irq_valid_i = 1; irq_handler_i = 32'h0000_0600; irq_cause_i = 32'h8000_0007;
    irq_epc_i = 32'h0000_0800; mstatus_i = 32'h0000_0008;
    tick();
    irq_valid_i = 0;
    n = 0;
    while (!mepc_we_o && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (!mepc_we_o) begin
      miscompares++;
      $display("FAIL rst_reach_save: mepc_we=%0b, expected 1", mepc_we_o);
    end
    rst_i = 1;
    #1;
    vectors++;
    if ({stall_o, flush_o, redirect_valid_o, mepc_we_o, mcause_we_o, mstatus_we_o,
         trap_active_o, mepc_o, mcause_o, mstatus_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: stall=%0b mepc_we=%0b active=%0b mepc=%h, expected all 0",
               stall_o, mepc_we_o, trap_active_o, mepc_o);
    end
    tick();
    rst_i = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (redirect_valid_o || trap_active_o || mepc_we_o) n++;
    end
    vectors++;
    if (n != 0) begin
      miscompares++;
      $display("FAIL rst_after_release: %0d active cycles, expected 0", n);
    end
  endtask

  initial begin
    test_reset();
    test_irq();
    test_exc_over_irq();
    test_pipe_busy();
    test_mret();
    test_irq_pulse();
    test_back_to_back();
    test_reset_mid_save();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
